// File: rtl/lnx_result_buffer.sv
// lnx_result_buffer: first-word-fall-through result queue between the ln(x)
// controller and the host, accepting exactly one result per VALID assertion.
module lnx_result_buffer #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              VALID,
  input  logic [WIDTH-1:0]  DIN,
  output logic              READY,
  output logic [WIDTH-1:0]  DOUT,
  output logic              DOUT_VALID,
  input  logic              DOUT_ACK,
  output logic [ADDR_W:0]   COUNT,
  output logic              DROP
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic              armed;
  logic              valid_q;
  logic              push;
  logic              pop;

  // READY comes from the registered count only, so a pop never frees a slot
  // for a push in the same cycle.
  assign READY      = (COUNT != FULL_COUNT);
  assign DOUT_VALID = (COUNT != '0);
  assign DOUT       = DOUT_VALID ? mem[rp] : '0;
  assign push       = VALID && READY && armed;
  assign pop        = DOUT_ACK && DOUT_VALID;

  always_ff @(posedge CLK) begin
    if (push) mem[wp] <= DIN;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wp      <= '0;
      rp      <= '0;
      COUNT   <= '0;
      armed   <= 1'b1;
      valid_q <= 1'b0;
      DROP    <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   COUNT <= COUNT + 1'b1;
        2'b01:   COUNT <= COUNT - 1'b1;
        default: COUNT <= COUNT;
      endcase
      // Falling VALID while still armed means the result was withdrawn unseen.
      if (valid_q && !VALID && armed) DROP <= 1'b1;
      if (!VALID)
        armed <= 1'b1;
      else if (push)
        armed <= 1'b0;
      valid_q <= VALID;
    end
  end

endmodule

// File: tb/tb_lnx_result_buffer.sv
// Testbench for lnx_result_buffer: directed traffic checked every cycle against
// a queue-based model, plus literal expectations at key points.
module tb_lnx_result_buffer;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              VALID;
  logic [WIDTH-1:0]  DIN;
  logic              READY;
  logic [WIDTH-1:0]  DOUT;
  logic              DOUT_VALID;
  logic              DOUT_ACK;
  logic [ADDR_W:0]   COUNT;
  logic              DROP;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] popped[$];
  bit model_taken;
  bit model_prev;
  bit model_drop;
  bit model_push;

  lnx_result_buffer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .VALID(VALID),
    .DIN(DIN),
    .READY(READY),
    .DOUT(DOUT),
    .DOUT_VALID(DOUT_VALID),
    .DOUT_ACK(DOUT_ACK),
    .COUNT(COUNT),
    .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  // Reference: a queue of stored results; a VALID assertion delivers at most
  // one result, and dropping VALID before delivery is a withdrawal.
  always @(posedge CLK) begin
    if (RESET) begin
      model_q.delete();
      model_taken = 1'b0;
      model_prev  = 1'b0;
      model_drop  = 1'b0;
    end else begin
      if (model_prev && !VALID && !model_taken) model_drop = 1'b1;
      model_push = VALID && !model_taken && (model_q.size() < DEPTH);
      if (DOUT_ACK && model_q.size() > 0) model_q.delete(0);
      if (model_push) begin
        model_q.push_back(DIN);
        model_taken = 1'b1;
      end
      if (!VALID) model_taken = 1'b0;
      model_prev = VALID;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareModel();
    logic [WIDTH-1:0] exp_dout;
    exp_dout = (model_q.size() > 0) ? model_q[0] : '0;
    checkOutput("model_count", 32'(COUNT), 32'(model_q.size()));
    checkOutput("model_ready", 32'(READY), 32'(model_q.size() != DEPTH));
    checkOutput("model_dout_valid", 32'(DOUT_VALID), 32'(model_q.size() != 0));
    checkOutput("model_dout", 32'(DOUT), 32'(exp_dout));
    checkOutput("model_drop", 32'(DROP), 32'(model_drop));
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then compare.
  task automatic applyStimulus(input bit rst, input bit v, input logic [WIDTH-1:0] d, input bit a);
    RESET    = rst;
    VALID    = v;
    DIN      = d;
    DOUT_ACK = a;
    if (!rst && a && DOUT_VALID === 1'b1) popped.push_back(DOUT);
    @(posedge CLK);
    #2;
    compareModel();
  endtask

  task automatic pushOne(input logic [WIDTH-1:0] d);
    applyStimulus(1'b0, 1'b1, d, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    $display("[TB] starting lnx_result_buffer bench");

    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("reset_ready", 32'(READY), 32'd1);
    checkOutput("reset_dout_valid", 32'(DOUT_VALID), 32'd0);
    checkOutput("reset_dout", 32'(DOUT), 32'd0);
    checkOutput("reset_count", 32'(COUNT), 32'd0);
    checkOutput("reset_drop", 32'(DROP), 32'd0);

    applyStimulus(1'b0, 1'b1, 16'h1A2B, 1'b0);
    checkOutput("single_valid_latency", 32'(DOUT_VALID), 32'd1);
    checkOutput("single_dout", 32'(DOUT), 32'h1A2B);
    applyStimulus(1'b0, 1'b1, 16'h1A2B, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h1A2B, 1'b0);
    checkOutput("single_one_push", 32'(COUNT), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("single_pop_count", 32'(COUNT), 32'd0);
    checkOutput("single_pop_dout", 32'(DOUT), 32'd0);
    checkOutput("single_no_drop", 32'(DROP), 32'd0);

    for (int i = 1; i <= 4; i++) pushOne(16'(i));
    checkOutput("full_count", 32'(COUNT), 32'd4);
    checkOutput("full_ready", 32'(READY), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h0005, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0005, 1'b0);
    checkOutput("full_blocked_count", 32'(COUNT), 32'd4);
    checkOutput("full_head", 32'(DOUT), 32'h0001);
    applyStimulus(1'b0, 1'b1, 16'h0005, 1'b1);
    checkOutput("full_pop_count", 32'(COUNT), 32'd3);
    checkOutput("full_pop_ready", 32'(READY), 32'd1);
    checkOutput("full_pop_head", 32'(DOUT), 32'h0002);
    applyStimulus(1'b0, 1'b1, 16'h0005, 1'b0);
    checkOutput("full_late_push", 32'(COUNT), 32'd4);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("full_no_drop", 32'(DROP), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("full_drained", 32'(COUNT), 32'd0);

    popped.delete();
    pushOne(16'h0010);
    pushOne(16'h0011);
    applyStimulus(1'b0, 1'b1, 16'h0012, 1'b1);
    checkOutput("wrap_simul_count", 32'(COUNT), 32'd2);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    for (int k = 16'h13; k <= 16'h19; k++) begin
      applyStimulus(1'b0, 1'b1, 16'(k), 1'b1);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("wrap_empty_ack", 32'(COUNT), 32'd0);
    checkOutput("wrap_pop_total", 32'(popped.size()), 32'd10);
    for (int i = 0; i < popped.size(); i++)
      checkOutput("wrap_order", 32'(popped[i]), 32'h10 + 32'(i));
    checkOutput("wrap_no_drop", 32'(DROP), 32'd0);

    for (int i = 0; i < 4; i++) pushOne(16'h0020 + 16'(i));
    applyStimulus(1'b0, 1'b1, 16'h0077, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0077, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("drop_set", 32'(DROP), 32'd1);
    checkOutput("drop_count", 32'(COUNT), 32'd4);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    pushOne(16'h0030);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("drop_sticky", 32'(DROP), 32'd1);

    pushOne(16'h00A1);
    pushOne(16'h00A2);
    pushOne(16'h00A3);
    checkOutput("midreset_pre_count", 32'(COUNT), 32'd3);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("midreset_count", 32'(COUNT), 32'd0);
    checkOutput("midreset_dout_valid", 32'(DOUT_VALID), 32'd0);
    checkOutput("midreset_ready", 32'(READY), 32'd1);
    checkOutput("midreset_drop", 32'(DROP), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b0);
    checkOutput("midreset_push_dout", 32'(DOUT), 32'hBEEF);
    checkOutput("midreset_push_count", 32'(COUNT), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
